// File: rtl/oh_fifo_pkg.sv
// Shared helpers for the synchronous FIFO controller: pointer comparison,
// occupancy arithmetic and the smallest supported depth.
package oh_fifo_pkg;

    localparam int MIN_DEPTH = 2;

    typedef struct packed {
        logic full;
        logic empty;
    } ptr_flags_t;

    // Pointers are AW+1 bits wide, zero-extended to 32 bits by the caller.
    function automatic ptr_flags_t ptr_compare(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int unsigned aw
    );
        ptr_flags_t  flags;
        logic [31:0] mask;
        logic [31:0] diff;
        mask        = (32'h1 << (aw + 1)) - 32'h1;
        diff        = (wr_ptr ^ rd_ptr) & mask;
        flags.empty = (diff == 32'h0);
        flags.full  = (diff == (32'h1 << aw));
        return flags;
    endfunction

    function automatic logic [31:0] ptr_count(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int unsigned aw
    );
        logic [31:0] mask;
        mask = (32'h1 << (aw + 1)) - 32'h1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/oh_fifo_ptr.sv
// Wrapping FIFO pointer: W-bit register with increment enable and
// synchronous clear; also exposes its next-state value.
module oh_fifo_ptr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_next
);

    logic [W-1:0] r_ptr;

    assign ptr_next = clear ? '0 : (inc ? r_ptr + W'(1) : r_ptr);
    assign ptr      = r_ptr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/oh_fifo_sync_ctrl.sv
// Single-clock FIFO controller driving a registered-read dual-port RAM.
// Define OH_FIFO_CTRL_ERR_EN to add sticky overflow/underflow outputs.
module oh_fifo_sync_ctrl
    import oh_fifo_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int AW        = $clog2(DEPTH),
    parameter int PROG_FULL = DEPTH - 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          full,
    output logic          prog_full,
    output logic          empty,
    output logic          rd_valid,
`ifdef OH_FIFO_CTRL_ERR_EN
    output logic          overflow,
    output logic          underflow,
`endif
    output logic [AW:0]   count,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr
);

    generate
        if (DEPTH < MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("oh_fifo_sync_ctrl: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic        r_full;
    logic        r_empty;
    logic        r_prog_full;
    logic        r_rd_valid;
    logic [AW:0] r_count;

    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_wr_ptr;
    logic [AW:0] w_wr_ptr_next;
    logic [AW:0] w_rd_ptr;
    logic [AW:0] w_rd_ptr_next;
    logic [AW:0] w_count_next;
    logic        w_prog_full_next;
    ptr_flags_t  w_flags_next;

    // clear outranks both requests, so the RAM sees no access in that cycle
    assign w_push = wr_en & ~r_full  & ~clear;
    assign w_pop  = rd_en & ~r_empty & ~clear;

    oh_fifo_ptr #(.W(AW + 1)) u_wr_ptr (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (clear),
        .inc      (w_push),
        .ptr      (w_wr_ptr),
        .ptr_next (w_wr_ptr_next)
    );

    oh_fifo_ptr #(.W(AW + 1)) u_rd_ptr (
        .clk      (clk),
        .nreset   (nreset),
        .clear    (clear),
        .inc      (w_pop),
        .ptr      (w_rd_ptr),
        .ptr_next (w_rd_ptr_next)
    );

    // Flags come from the next-state pointers so they are exact right after the edge
    assign w_flags_next     = ptr_compare(32'(w_wr_ptr_next), 32'(w_rd_ptr_next), AW);
    assign w_count_next     = (AW + 1)'(ptr_count(32'(w_wr_ptr_next), 32'(w_rd_ptr_next), AW));
    assign w_prog_full_next = (32'(w_count_next) >= 32'(PROG_FULL));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_prog_full <= 1'b0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_full      <= w_flags_next.full;
            r_empty     <= w_flags_next.empty;
            r_prog_full <= w_prog_full_next;
            r_count     <= w_count_next;
            r_rd_valid  <= w_pop;
        end
    end

`ifdef OH_FIFO_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign full        = r_full;
    assign empty       = r_empty;
    assign prog_full   = r_prog_full;
    assign rd_valid    = r_rd_valid;
    assign count       = r_count;
    assign mem_wr_en   = w_push;
    assign mem_wr_addr = w_wr_ptr[AW-1:0];
    assign mem_rd_en   = w_pop;
    assign mem_rd_addr = w_rd_ptr[AW-1:0];

endmodule

// File: tb/tb_oh_fifo_sync_ctrl.sv
// Directed bench for oh_fifo_sync_ctrl at DEPTH=8, PROG_FULL=4 with a
// behavioural registered-read RAM attached to the memory port.
module tb_oh_fifo_sync_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          nreset;
    logic          clear;
    logic          wr_en;
    logic          rd_en;
    logic          full;
    logic          prog_full;
    logic          empty;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
`ifdef OH_FIFO_CTRL_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    logic [7:0] wdata;
    logic [7:0] rd_dout;
    logic [7:0] ram [0:DEPTH-1];

    int n_cmp = 0;
    int n_err = 0;

    // bench-side model
    int         m_count = 0;
    logic [2:0] m_wa = '0;
    logic [2:0] m_ra = '0;
    logic [7:0] m_q[$];

    always #5 clk = ~clk;

    oh_fifo_sync_ctrl #(.DEPTH(DEPTH), .AW(AW), .PROG_FULL(4)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .clear       (clear),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .full        (full),
        .prog_full   (prog_full),
        .empty       (empty),
        .rd_valid    (rd_valid),
`ifdef OH_FIFO_CTRL_ERR_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .count       (count),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr)
    );

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= wdata;
        if (mem_rd_en) rd_dout <= ram[mem_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wa    = '0;
        m_ra    = '0;
        m_q.delete();
    endtask

    // One clock of traffic: checks RAM controls, then the registered state
    task automatic xfer(input logic w, input logic r, input logic [7:0] d);
        logic       push_ok;
        logic       pop_ok;
        logic [7:0] exp_d;
        exp_d   = '0;
        wr_en   = w;
        rd_en   = r;
        wdata   = d;
        #1;
        push_ok = w && (m_count != DEPTH);
        pop_ok  = r && (m_count != 0);
        check("mem_wr_en", mem_wr_en, push_ok);
        if (push_ok) check("mem_wr_addr", mem_wr_addr, m_wa);
        check("mem_rd_en", mem_rd_en, pop_ok);
        if (pop_ok) check("mem_rd_addr", mem_rd_addr, m_ra);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (push_ok) begin
            m_q.push_back(d);
            m_wa++;
            m_count++;
        end
        if (pop_ok) begin
            exp_d = m_q.pop_front();
            m_ra++;
            m_count--;
        end
        check("count", count, m_count);
        check("full", full, m_count == DEPTH);
        check("empty", empty, m_count == 0);
        check("prog_full", prog_full, m_count >= 4);
        check("rd_valid", rd_valid, pop_ok);
        if (pop_ok) check("rd_dout", rd_dout, exp_d);
        $display("xfer wr=%0d rd=%0d din=%h push=%0d pop=%0d count=%0d dout=%h",
                 w, r, d, push_ok, pop_ok, count, rd_dout);
    endtask

    task automatic do_clear(input logic w, input logic r);
        clear = 1'b1;
        wr_en = w;
        rd_en = r;
        #1;
        check("clr_mem_wr_en", mem_wr_en, 1'b0);
        check("clr_mem_rd_en", mem_rd_en, 1'b0);
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        check("clr_count", count, 0);
        check("clr_empty", empty, 1'b1);
        check("clr_full", full, 1'b0);
        check("clr_prog_full", prog_full, 1'b0);
        check("clr_rd_valid", rd_valid, 1'b0);
        $display("clear wr=%0d rd=%0d count=%0d empty=%0d", w, r, count, empty);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        nreset = 1'b0;
        clear  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wdata  = '0;
        repeat (3) @(posedge clk);
        #6;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 0);
        check("rst_rd_valid", rd_valid, 1'b0);
        nreset = 1'b1;
        tick();

        // reads while empty are ignored
        for (int i = 0; i < 3; i++) xfer(1'b0, 1'b1, 8'h00);
        check("rd_ptr_hold", mem_rd_addr, 0);

        // fill to full, then an extra push is dropped
        for (int i = 1; i <= 8; i++) xfer(1'b1, 1'b0, 8'(i * 8'h11));
        check("fill_full", full, 1'b1);
        check("fill_count", count, 8);
        xfer(1'b1, 1'b0, 8'hEE);
        check("ovf_count", count, 8);

        // full with both requests: pop only
        xfer(1'b1, 1'b1, 8'hDD);
        check("full_both_dout", rd_dout, 8'h11);
        check("full_both_count", count, 7);

        // drain remaining entries
        for (int i = 0; i < 7; i++) xfer(1'b0, 1'b1, 8'h00);
        check("drain_empty", empty, 1'b1);
        check("drain_last", rd_dout, 8'h88);
        xfer(1'b0, 1'b0, 8'h00);

        // empty with both requests: push only
        xfer(1'b1, 1'b1, 8'hA0);
        check("empty_both_count", count, 1);

        // concurrent traffic around the ring
        xfer(1'b1, 1'b0, 8'hA1);
        xfer(1'b1, 1'b0, 8'hA2);
        for (int i = 0; i < 20; i++) xfer(1'b1, 1'b1, 8'(8'hB0 + i));
        check("conc_count", count, 3);

        // clear with pending traffic at count=5
        xfer(1'b1, 1'b0, 8'hC0);
        xfer(1'b1, 1'b0, 8'hC1);
        check("pre_clear_count", count, 5);
        do_clear(1'b1, 1'b1);
        check("post_clear_waddr", mem_wr_addr, 0);
        xfer(1'b1, 1'b0, 8'h5A);
        check("post_clear_raddr", mem_rd_addr, 0);
        xfer(1'b0, 1'b1, 8'h00);
        check("post_clear_dout", rd_dout, 8'h5A);

        // asynchronous reset mid-operation
        xfer(1'b1, 1'b0, 8'h61);
        xfer(1'b1, 1'b1, 8'h62);
        nreset = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1'b1);
        check("arst_rd_valid", rd_valid, 1'b0);
        #3;
        nreset = 1'b1;
        model_reset();
        tick();
        xfer(1'b0, 1'b1, 8'h00);
        check("arst_no_pop", rd_valid, 1'b0);

`ifdef OH_FIFO_CTRL_ERR_EN
        check("err_ovf_rst", overflow, 1'b0);
        for (int i = 0; i < 8; i++) xfer(1'b1, 1'b0, 8'(8'h70 + i));
        xfer(1'b1, 1'b0, 8'hFF);
        check("err_ovf_set", overflow, 1'b1);
        xfer(1'b0, 1'b0, 8'h00);
        check("err_ovf_sticky", overflow, 1'b1);
        check("err_udf_clr", underflow, 1'b0);
        for (int i = 0; i < 8; i++) xfer(1'b0, 1'b1, 8'h00);
        xfer(1'b0, 1'b1, 8'h00);
        check("err_udf_set", underflow, 1'b1);
        do_clear(1'b0, 1'b0);
        check("err_ovf_cleared", overflow, 1'b0);
        check("err_udf_cleared", underflow, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
